// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//   Read-side master for a single-port read-first BRAM. A start command
//   latches base_addr/len, then LEN consecutive words (address wraps modulo
//   the RAM depth) are read and presented on a valid/ready stream. A 2-entry
//   output FIFO absorbs the BRAM's 1-cycle read latency, so a steadily ready
//   consumer receives one word per cycle.
//
// Ports
//   clka       clock, all logic on posedge
//   rsta       synchronous active-high reset
//   start      launch transfer (sampled only while busy=0)
//   base_addr  first BRAM address, sampled with start
//   len        word count 0..RAM_DEPTH, sampled with start
//   busy       transfer in progress
//   done       one-cycle pulse at transfer end
//   bram_en    BRAM ena
//   bram_we    BRAM wea, tied low
//   bram_addr  BRAM addra
//   bram_dout  BRAM douta, valid one edge after bram_en
//   m_data     stream data (FIFO head)
//   m_valid    stream valid (FIFO non-empty)
//   m_ready    stream ready
//   m_last     (only with BRAM_RD_LAST_EN) marks the final word of a transfer
//
// Configuration macro: BRAM_RD_LAST_EN adds the m_last output.
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef BRAM_RD_LAST_EN
    ,
    output logic                  m_last
`endif
);

    localparam logic [ADDR_WIDTH:0] LEN_ZERO = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;

    logic                    busy_s;
    logic                    issue_s;
    logic                    pop_s;
    logic                    m_valid_s;
    logic                    start_go_s;
    logic                    start_zero_s;
    logic                    last_pop_s;
    logic [2:0]              occ_s;
    logic [2:0]              room_s;

    logic [ADDR_WIDTH-1:0]   bram_addr_r;
    logic [ADDR_WIDTH:0]     remaining_r;   // reads still to issue
    logic [ADDR_WIDTH:0]     out_left_r;    // words still to hand to the stream
    logic                    inflight_r;    // read issued last cycle, data arrives now
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   fifo_mem_r [0:1];
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;
    logic [1:0]              count_r;

    // Handshake and command decode shared by the FSM and datapath.
    always_comb begin
        m_valid_s    = (count_r != 2'd0);
        pop_s        = m_valid_s & m_ready;
        start_go_s   = (state_r == ST_IDLE) & start & (len != LEN_ZERO);
        start_zero_s = (state_r == ST_IDLE) & start & (len == LEN_ZERO);
        // Last word can only leave after the final read was issued (DRAIN).
        last_pop_s   = (state_r == ST_DRAIN) & pop_s & (out_left_r == LEN_ONE);
        // FIFO occupancy plus the word still coming out of the BRAM; a pop this
        // cycle frees one slot, so issuing is allowed while occ < 2 + pop.
        occ_s        = {1'b0, count_r} + {2'b00, inflight_r};
        room_s       = 3'd2 + {2'b00, pop_s};
    end

    // FSM state register.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_go_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && (remaining_r == LEN_ONE)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and read-issue decision.
    always_comb begin
        busy_s  = 1'b0;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s  = 1'b0;
                issue_s = 1'b0;
            end
            ST_READ: begin
                busy_s = 1'b1;
                if ((remaining_r != LEN_ZERO) && (occ_s < room_s)) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                busy_s  = 1'b1;
                issue_s = 1'b0;
            end
            default: begin
                busy_s  = 1'b0;
                issue_s = 1'b0;
            end
        endcase
    end

    // Address/length counters, in-flight tracking and done pulse.
    always_ff @(posedge clka) begin
        if (rsta) begin
            bram_addr_r <= {ADDR_WIDTH{1'b0}};
            remaining_r <= LEN_ZERO;
            out_left_r  <= LEN_ZERO;
            inflight_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (start_go_s) begin
                bram_addr_r <= base_addr;
                remaining_r <= len;
            end else if (issue_s) begin
                // Natural overflow gives the RAM_DEPTH-1 -> 0 wrap.
                bram_addr_r <= bram_addr_r + ADDR_WIDTH'(1);
                remaining_r <= remaining_r - LEN_ONE;
            end
            if (start_go_s) begin
                out_left_r <= len;
            end else if (pop_s) begin
                out_left_r <= out_left_r - LEN_ONE;
            end
            inflight_r <= issue_s;
            done_r     <= start_zero_s | last_pop_s;
        end
    end

    // Two-entry output FIFO: capture returning BRAM data, pop on handshake.
    always_ff @(posedge clka) begin
        if (rsta) begin
            fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
            fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_mem_r[wr_ptr_r] <= bram_dout;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({inflight_r, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign busy      = busy_s;
    assign done      = done_r;
    assign bram_en   = issue_s;
    assign bram_we   = 1'b0;
    assign bram_addr = bram_addr_r;
    assign m_valid   = m_valid_s;
    assign m_data    = fifo_mem_r[rd_ptr_r];
`ifdef BRAM_RD_LAST_EN
    assign m_last    = m_valid_s & (out_left_r == LEN_ONE);
`endif

endmodule
